// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared constants, state enum and second-byte decode for cmd_decoder
package cmd_pkg;

  localparam logic [7:0] CMD_HDR = 8'hCA;
  localparam int         CMD_NUM = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } cmd_state_e;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } cmd_lo_t;

  // Second byte must repeat its nibble and the nibble must name one of the eight triggers.
  function automatic cmd_lo_t cmd_lo_valid(input logic [7:0] b);
    cmd_lo_t r;
    r.ok  = (b[7:4] == b[3:0]) && (b[3:0] >= 4'd1) && (b[3:0] <= 4'd8);
    r.idx = 3'(b[3:0] - 4'd1);
    return r;
  endfunction

endpackage

// File: rtl/cmd_decoder_pulse_stretch.sv
// rtl/cmd_decoder_pulse_stretch.sv - one trigger stretch counter; load wins over decrement
module pulse_stretch #(
  parameter int PULSE_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(PULSE_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/cmd_decoder.sv
// rtl/cmd_decoder.sv - two-byte trigger command decoder; optional WAIT_LO timeout under CMD_DECODE_TIMEOUT_EN
module cmd_decoder
  import cmd_pkg::*;
#(
  parameter logic [7:0] HDR         = CMD_HDR,
  parameter int         PULSE_LEN   = 4,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_code,
  input  logic       cmd_codev,
  input  logic       err_clr,
  output logic [7:0] trig,
  output logic       cmd_valid,
  output logic [2:0] cmd_idx,
  output logic [7:0] err_cnt
);

  cmd_state_e    state_q, state_d;
  cmd_lo_t       lo;
  logic          accept_c, err_c, tmo_hit;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_idx_q, cmd_idx_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [CMD_NUM-1:0] load;

  assign lo = cmd_lo_valid(cmd_code);

`ifdef CMD_DECODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Any valid byte, or leaving WAIT_LO, restarts the idle count.
  assign tmo_hit = (state_q == WAIT_LO) && !cmd_codev && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if ((state_q == WAIT_LO) && !cmd_codev && !tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cmd_codev) begin
      case (state_q)
        IDLE:    if (cmd_code == HDR) state_d = WAIT_LO;
        WAIT_LO: if (lo.ok || (cmd_code != HDR)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    accept_c = 1'b0;
    err_c    = 1'b0;
    if (cmd_codev) begin
      if (state_q == WAIT_LO) begin
        accept_c = lo.ok;
        err_c    = !lo.ok;
      end else begin
        err_c    = (cmd_code != HDR);
      end
    end else begin
      err_c = tmo_hit;
    end
  end

  always_comb begin
    cmd_valid_d = accept_c;
    cmd_idx_d   = accept_c ? lo.idx : cmd_idx_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  for (genvar i = 0; i < CMD_NUM; i++) begin : g_str
    assign load[i] = accept_c && (lo.idx == 3'(i));
    pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_str (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[i]),
      .active (trig[i])
    );
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_idx   = cmd_idx_q;
  assign err_cnt   = err_cnt_q;

endmodule
